// File: rtl/avalon_slave_bridge.sv
// Avalon-MM burst slave to user-bus address/data channels; one address per burst, wlast tracked per beat.
// Latency: writes and commands 0 cycles; reads 1 cycle through the read FIFO (0 cycles without it).
// Backpressure: avs_waitrequest follows awready/wready/arready; reads also stall on read-beat credit.
// Optional feature: define AVALON_SLAVE_BRIDGE_READ_FIFO_EN to build the read FIFO and credit admission.
module avalon_slave_bridge #(
  parameter int C_AVS_ADDR_WIDTH   = 32,
  parameter int C_AVS_DATA_WIDTH   = 32,
  parameter int C_BURSTCOUNT_WIDTH = 9,
  parameter int C_RFIFO_DEPTH      = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // write address channel
  output logic [C_AVS_ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                      awlen,
  output logic                            awvalid,
  input  logic                            awready,
  // write data channel
  output logic [C_AVS_DATA_WIDTH-1:0]     wdata,
  output logic [C_AVS_DATA_WIDTH/8-1:0]   wstrb,
  output logic                            wlast,
  output logic                            wvalid,
  input  logic                            wready,
  // read address channel
  output logic [C_AVS_ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                      arlen,
  output logic                            arvalid,
  input  logic                            arready,
  // read data channel
  input  logic [C_AVS_DATA_WIDTH-1:0]     rdata,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready,
  // Avalon-MM slave
  input  logic [C_AVS_ADDR_WIDTH-1:0]     avs_address,
  input  logic [C_AVS_DATA_WIDTH/8-1:0]   avs_byteenable,
  input  logic [C_BURSTCOUNT_WIDTH-1:0]   avs_burstcount,
  output logic                            avs_waitrequest,
  input  logic                            avs_read,
  output logic [C_AVS_DATA_WIDTH-1:0]     avs_readdata,
  output logic                            avs_readdatavalid,
  input  logic                            avs_write,
  input  logic [C_AVS_DATA_WIDTH-1:0]     avs_writedata
);

  typedef enum logic [0:0] {ST_IDLE, ST_WBURST} state_t;

  state_t                        state_q, state_d;
  logic [7:0]                    wrem_q, wrem_d;
  logic [C_BURSTCOUNT_WIDTH-1:0] len;
  logic [C_BURSTCOUNT_WIDTH-1:0] len_m1;
  logic                          credit_ok;
  logic                          rd_acc;

  // burstcount of zero means a single beat
  assign len    = (avs_burstcount == '0) ? C_BURSTCOUNT_WIDTH'(1) : avs_burstcount;
  assign len_m1 = len - C_BURSTCOUNT_WIDTH'(1);

  assign awaddr = avs_address;
  assign araddr = avs_address;
  assign awlen  = 8'(len_m1);
  assign arlen  = 8'(len_m1);
  assign wdata  = avs_writedata;
  assign wstrb  = avs_byteenable;

  // next-state and handshake outputs; write wins over read, everything idles during reset
  always_comb begin
    state_d         = state_q;
    wrem_d          = wrem_q;
    awvalid         = 1'b0;
    wvalid          = 1'b0;
    wlast           = 1'b0;
    arvalid         = 1'b0;
    avs_waitrequest = 1'b0;
    rd_acc          = 1'b0;
    if (ARESET) begin
      avs_waitrequest = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (avs_write) begin
            awvalid         = 1'b1;
            wvalid          = 1'b1;
            wlast           = (len == C_BURSTCOUNT_WIDTH'(1));
            avs_waitrequest = !(awready && wready);
            if (awready && wready && (len != C_BURSTCOUNT_WIDTH'(1))) begin
              state_d = ST_WBURST;
              wrem_d  = 8'(len_m1);
            end
          end else if (avs_read) begin
            arvalid         = credit_ok;
            avs_waitrequest = !(credit_ok && arready);
            rd_acc          = credit_ok && arready;
          end
        end
        ST_WBURST: begin
          wvalid = avs_write;
          wlast  = (wrem_q == 8'd1);
          // a read cannot be issued mid-burst, so hold it off rather than drop it
          avs_waitrequest = avs_write ? !wready : avs_read;
          if (avs_write && wready) begin
            wrem_d = wrem_q - 8'd1;
            if (wrem_q == 8'd1) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // write FSM state and remaining-beat counter
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      wrem_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wrem_q  <= wrem_d;
    end
  end

`ifdef AVALON_SLAVE_BRIDGE_READ_FIFO_EN
  localparam int OW = $clog2(C_RFIFO_DEPTH + 1);
  localparam int PW = $clog2(C_RFIFO_DEPTH);

  logic [OW-1:0]               outstanding_q, outstanding_d;
  logic [PW:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW:0]                 rd_ptr_q, rd_ptr_d;
  logic [C_AVS_DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                        rd_vld_q, rd_vld_d;
  logic [C_AVS_DATA_WIDTH-1:0] rfifo_mem [C_RFIFO_DEPTH];
  logic                        fifo_empty, fifo_full;
  logic                        push, bypass;
  logic [31:0]                 credit_sum;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rready     = !fifo_full;
  assign push       = rvalid && !fifo_full;
  // an incoming beat into an empty FIFO goes straight to the output register to keep 1-cycle latency
  assign bypass     = push && fifo_empty;

  // admission uses the registered count only; beats leaving this cycle are credited next cycle
  assign credit_sum = 32'(outstanding_q) + 32'(len);
  assign credit_ok  = (credit_sum <= 32'(C_RFIFO_DEPTH));

  assign avs_readdata      = rd_dat_q;
  assign avs_readdatavalid = rd_vld_q;

  // FIFO pointers, output register and outstanding-beat accounting
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_dat_d      = rd_dat_q;
    rd_vld_d      = 1'b0;
    if (push && !bypass) begin
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (!fifo_empty) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
      rd_dat_d = rfifo_mem[rd_ptr_q[PW-1:0]];
      rd_vld_d = 1'b1;
    end else if (bypass) begin
      rd_dat_d = rdata;
      rd_vld_d = 1'b1;
    end
    outstanding_d = OW'(32'(outstanding_q) + (rd_acc ? 32'(len) : 32'd0) - 32'(rd_vld_q));
  end

  // read-path registers; reset flushes the FIFO without draining it
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_dat_q      <= '0;
      rd_vld_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_dat_q      <= rd_dat_d;
      rd_vld_q      <= rd_vld_d;
    end
  end

  // FIFO storage, written only when the beat cannot bypass
  always_ff @(posedge ACLK) begin
    if (push && !bypass) begin
      rfifo_mem[wr_ptr_q[PW-1:0]] <= rdata;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, rlast};
`else
  assign credit_ok         = 1'b1;
  assign rready            = 1'b1;
  assign avs_readdata      = rdata;
  assign avs_readdatavalid = rvalid && !ARESET;

  logic unused_ok;
  assign unused_ok = &{1'b0, rlast, rd_acc};
`endif

endmodule

// File: tb/tb_avalon_slave_bridge.sv
// Directed bench for avalon_slave_bridge: writes, bursts with stalls, reset mid-burst, reads and credit.
// Inputs driven 1 ns after the rising edge, outputs sampled 1 ns or more later.
// Read checks follow whichever read path is built.
module tb_avalon_slave_bridge;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BCW   = 9;
  localparam int DEPTH = 16;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic            arvalid, arready;
  logic [DW-1:0]   rdata;
  logic            rlast, rvalid, rready;
  logic [AW-1:0]   avs_address;
  logic [DW/8-1:0] avs_byteenable;
  logic [BCW-1:0]  avs_burstcount;
  logic            avs_waitrequest, avs_read, avs_readdatavalid, avs_write;
  logic [DW-1:0]   avs_readdata, avs_writedata;

  int n_cmp = 0;
  int n_err = 0;

  avalon_slave_bridge #(
    .C_AVS_ADDR_WIDTH(AW), .C_AVS_DATA_WIDTH(DW),
    .C_BURSTCOUNT_WIDTH(BCW), .C_RFIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
    .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_write(avs_write),
    .avs_writedata(avs_writedata)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // a single-beat read with arready low shows arvalid only when the FSM is idle
  task automatic probe_idle(input string tag);
    avs_write      = 1'b0;
    avs_read       = 1'b1;
    avs_burstcount = 9'd1;
    arready        = 1'b0;
    settle();
    chk(tag, arvalid, 1);
    avs_read = 1'b0;
  endtask

  initial begin
    ARESET         = 1'b1;
    awready        = 1'b1;
    wready         = 1'b1;
    arready        = 1'b1;
    rdata          = '0;
    rlast          = 1'b0;
    rvalid         = 1'b1;
    avs_address    = '0;
    avs_byteenable = 4'hF;
    avs_burstcount = 9'd1;
    avs_read       = 1'b0;
    avs_write      = 1'b1;
    avs_writedata  = '0;

    // reset: valids held low and waitrequest high even with requests present
    repeat (2) @(posedge ACLK);
    #2;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_waitreq", avs_waitrequest, 1);
    chk("rst_rdv", avs_readdatavalid, 0);
    ARESET    = 1'b0;
    avs_write = 1'b0;
    rvalid    = 1'b0;
    settle();
    chk("idle_waitreq", avs_waitrequest, 0);
`ifdef AVALON_SLAVE_BRIDGE_READ_FIFO_EN
    chk("rst_readdata", avs_readdata, 0);
`endif

    // single write
    tick();
    avs_address    = 32'h100;
    avs_burstcount = 9'd1;
    avs_writedata  = 32'hDEADBEEF;
    avs_byteenable = 4'h5;
    avs_write      = 1'b1;
    settle();
    chk("t1_awvalid", awvalid, 1);
    chk("t1_wvalid", wvalid, 1);
    chk("t1_wlast", wlast, 1);
    chk("t1_awlen", awlen, 0);
    chk("t1_awaddr", awaddr, 32'h100);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_wstrb", wstrb, 4'h5);
    chk("t1_waitreq", avs_waitrequest, 0);
    tick();
    probe_idle("t1_idle");

    // 4-beat write, wready low for 2 cycles on beat 3
    tick();
    avs_address    = 32'h200;
    avs_burstcount = 9'd4;
    avs_writedata  = 32'h11;
    avs_byteenable = 4'hF;
    avs_write      = 1'b1;
    settle();
    chk("t2_b1_awvalid", awvalid, 1);
    chk("t2_b1_awlen", awlen, 3);
    chk("t2_b1_wlast", wlast, 0);
    chk("t2_b1_waitreq", avs_waitrequest, 0);
    tick();
    avs_address    = 32'hFFF0;
    avs_burstcount = 9'd1;
    avs_writedata  = 32'h22;
    settle();
    chk("t2_b2_awvalid", awvalid, 0);
    chk("t2_b2_wvalid", wvalid, 1);
    chk("t2_b2_wlast", wlast, 0);
    chk("t2_b2_waitreq", avs_waitrequest, 0);
    tick();
    avs_writedata = 32'h33;
    wready        = 1'b0;
    settle();
    chk("t2_b3_stall1", avs_waitrequest, 1);
    chk("t2_b3_wvalid", wvalid, 1);
    tick();
    settle();
    chk("t2_b3_stall2", avs_waitrequest, 1);
    tick();
    wready = 1'b1;
    settle();
    chk("t2_b3_go", avs_waitrequest, 0);
    chk("t2_b3_wlast", wlast, 0);
    tick();
    avs_writedata = 32'h44;
    settle();
    chk("t2_b4_wlast", wlast, 1);
    chk("t2_b4_awvalid", awvalid, 0);
    chk("t2_b4_wdata", wdata, 32'h44);
    tick();
    probe_idle("t2_idle");

    // burstcount 0 is one beat
    tick();
    avs_address    = 32'h400;
    avs_burstcount = 9'd0;
    avs_write      = 1'b1;
    settle();
    chk("t3_awvalid", awvalid, 1);
    chk("t3_awlen", awlen, 0);
    chk("t3_wlast", wlast, 1);
    tick();
    probe_idle("t3_idle");

    // reset during beat 2 of a 4-beat write, then a 2-beat write
    tick();
    avs_address    = 32'h500;
    avs_burstcount = 9'd4;
    avs_write      = 1'b1;
    settle();
    chk("t4_b1_awvalid", awvalid, 1);
    tick();
    settle();
    chk("t4_b2_wvalid", wvalid, 1);
    chk("t4_b2_awvalid", awvalid, 0);
    ARESET = 1'b1;
    settle();
    chk("t4_rst_wvalid", wvalid, 0);
    chk("t4_rst_waitreq", avs_waitrequest, 1);
    tick();
    ARESET         = 1'b0;
    avs_address    = 32'h600;
    avs_burstcount = 9'd2;
    settle();
    chk("t4_n1_awvalid", awvalid, 1);
    chk("t4_n1_awlen", awlen, 1);
    chk("t4_n1_wlast", wlast, 0);
    tick();
    settle();
    chk("t4_n2_awvalid", awvalid, 0);
    chk("t4_n2_wvalid", wvalid, 1);
    chk("t4_n2_wlast", wlast, 1);
    tick();
    probe_idle("t4_idle");

    // read and write together: write wins
    tick();
    avs_address    = 32'h680;
    avs_burstcount = 9'd1;
    avs_write      = 1'b1;
    avs_read       = 1'b1;
    arready        = 1'b1;
    settle();
    chk("t5_arvalid", arvalid, 0);
    chk("t5_awvalid", awvalid, 1);
    tick();
    avs_write = 1'b0;
    avs_read  = 1'b0;
    arready   = 1'b0;

`ifdef AVALON_SLAVE_BRIDGE_READ_FIFO_EN
    // 8-beat read through the FIFO
    tick();
    avs_address    = 32'h300;
    avs_burstcount = 9'd8;
    avs_read       = 1'b1;
    arready        = 1'b1;
    settle();
    chk("r8_arvalid", arvalid, 1);
    chk("r8_arlen", arlen, 7);
    chk("r8_araddr", araddr, 32'h300);
    chk("r8_waitreq", avs_waitrequest, 0);
    tick();
    avs_read = 1'b0;
    arready  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1;
      rdata  = 32'hA0 + 32'(i);
      settle();
      chk("r8_rready", rready, 1);
      chk("r8_rdv", avs_readdatavalid, (i > 0));
      if (i > 0) chk("r8_rdata", avs_readdata, 32'hA0 + 32'(i - 1));
      tick();
    end
    rvalid = 1'b0;
    settle();
    chk("r8_last_rdv", avs_readdatavalid, 1);
    chk("r8_last_rdata", avs_readdata, 32'hA7);
    tick();
    settle();
    chk("r8_done_rdv", avs_readdatavalid, 0);
    // full-depth read admissible only if every earlier beat has been returned
    avs_read       = 1'b1;
    avs_burstcount = 9'd16;
    settle();
    chk("r8_outstanding_zero", arvalid, 1);
    avs_read = 1'b0;

    // credit: 12 outstanding blocks a read of 8 until 4 beats have left
    tick();
    avs_address    = 32'h700;
    avs_burstcount = 9'd12;
    avs_read       = 1'b1;
    arready        = 1'b1;
    settle();
    chk("cr12_arvalid", arvalid, 1);
    tick();
    avs_burstcount = 9'd8;
    for (int k = 0; k < 6; k++) begin
      rvalid = (k < 4);
      rdata  = 32'hB0 + 32'(k);
      settle();
      chk("cr8_arvalid", arvalid, (k == 5));
      chk("cr8_waitreq", avs_waitrequest, (k != 5));
      tick();
    end
    avs_burstcount = 9'd1;
    settle();
    chk("cr_full_arvalid", arvalid, 0);
    chk("cr_full_waitreq", avs_waitrequest, 1);
    avs_read = 1'b0;
    arready  = 1'b0;
`else
    // reads: command passthrough and combinational data path
    tick();
    avs_address    = 32'h300;
    avs_burstcount = 9'd8;
    avs_read       = 1'b1;
    arready        = 1'b1;
    settle();
    chk("r8_arvalid", arvalid, 1);
    chk("r8_arlen", arlen, 7);
    chk("r8_araddr", araddr, 32'h300);
    chk("r8_waitreq", avs_waitrequest, 0);
    arready = 1'b0;
    settle();
    chk("r8_stall_waitreq", avs_waitrequest, 1);
    chk("r8_stall_arvalid", arvalid, 1);
    avs_read = 1'b0;
    tick();
    rvalid = 1'b1;
    rdata  = 32'h5A5A1234;
    settle();
    chk("rd_rdv", avs_readdatavalid, 1);
    chk("rd_rdata", avs_readdata, 32'h5A5A1234);
    chk("rd_rready", rready, 1);
    rvalid = 1'b0;
    settle();
    chk("rd_rdv_off", avs_readdatavalid, 0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avalon_slave_bridge.md
# avalon_slave_bridge

Parametrised Avalon-MM slave to user-bus bridge that converts Avalon burst reads and writes into the address/data channel handshakes of the PyCoRAM user bus. It issues one address per burst and tracks write beats so that `wlast` is generated correctly. An optional read-response FIFO with credit-based read admission registers the read path and bounds outstanding read beats. It sits between an Avalon interconnect master and the user-logic memory/control port.

## Interface
Parameters:
- C_AVS_ADDR_WIDTH, 32, address width of both buses
- C_AVS_DATA_WIDTH, 32, data width; multiple of 8
- C_BURSTCOUNT_WIDTH, 9, width of `avs_burstcount`; maximum legal burst is 256
- C_RFIFO_DEPTH, 256, read FIFO depth; power of 2; must be ≥ the largest burst used

Ports:
- ACLK  in  1  single clock; all logic is rising-edge
- ARESET  in  1  asynchronous, active-high reset
- awaddr/awlen/awvalid  out  ADDR/8/1  write address; awready  in  1
- wdata/wstrb/wlast/wvalid  out  DATA/DATA/8/1/1  write data; wready  in  1
- araddr/arlen/arvalid  out  ADDR/8/1  read address; arready  in  1
- rdata/rlast/rvalid  in  DATA/1/1  read data; rready  out  1
- avs_address  in  ADDR  burst start address
- avs_byteenable  in  DATA/8  byte lanes
- avs_burstcount  in  C_BURSTCOUNT_WIDTH  beats in burst
- avs_waitrequest  out  1  stall current command or beat
- avs_read  in  1; avs_readdata  out  DATA; avs_readdatavalid  out  1
- avs_write  in  1; avs_writedata  in  DATA

## Operation
- Effective length: `len = (avs_burstcount==0) ? 1 : avs_burstcount`. `awlen = arlen = len-1`, truncated to 8 bits.
- Write FSM states: IDLE and WBURST. The beat counter `wrem` is 8 bits.
- IDLE, `avs_write=1`:
  - `awvalid=wvalid=1`; `wlast = (len==1)`.
  - The beat is accepted when `awready && wready`; `avs_waitrequest = !(awready && wready)`.
  - On accept with `len>1`, go to WBURST with `wrem=len-1`. Otherwise stay in IDLE.
- WBURST:
  - `awvalid=0`, `arvalid=0`, `wvalid=avs_write`, `wlast=(wrem==1)`.
  - The beat is accepted when `avs_write && wready`, and `wrem` decrements on accept.
  - Accepting with `wrem==1` returns to IDLE.
  - `avs_address` and `avs_burstcount` are ignored.
- Data fields pass straight through: `wdata=avs_writedata`, `wstrb=avs_byteenable`, `awaddr=araddr=avs_address`.
- Read in IDLE (`avs_read=1`, `avs_write=0`):
  - `arvalid = credit_ok`, where `credit_ok = (outstanding + len ≤ C_RFIFO_DEPTH)`.
  - The command is accepted on `arvalid && arready`; `avs_waitrequest = !(credit_ok && arready)`.
- If `avs_read` and `avs_write` are both high, the write wins and `arvalid=0`. Asserting both is illegal.
- `avs_waitrequest=0` when no command or beat is pending.
- `outstanding` counter (width ⌈log2(C_RFIFO_DEPTH+1)⌉):
  - Increments by `len` on read accept.
  - Decrements by 1 per `avs_readdatavalid` beat.
  - Both events in the same cycle apply the net change.
- Read FIFO:
  - `rready = !full`.
  - A beat is pushed on `rvalid && rready`.
  - The FIFO pops every cycle it is non-empty into registered `avs_readdata`/`avs_readdatavalid`.
  - `rlast` is ignored.
- Reset:
  - State→IDLE, `wrem=0`, `outstanding=0`, FIFO pointers cleared, `avs_readdatavalid=0`, `avs_readdata=0`.
  - While ARESET is high, all valid outputs are 0 and `avs_waitrequest=1`.
  - Reset mid-burst abandons the burst and flushes the FIFO without a drain.

## Timing
- Write beat accept to `wvalid` of the next beat: 0 cycles (combinational). Back-to-back beats run at 1 beat per cycle.
- Read latency with FIFO: an `rvalid&&rready` push in cycle N gives `avs_readdatavalid=1` in cycle N+1. Throughput is 1 beat per cycle.
- The credit check uses the registered `outstanding` value. A pop in the same cycle is not credited until the next cycle.
- FIFO full and push: `rready=0`, so no push occurs. The credit rule makes this unreachable in legal use.
- FIFO empty and pop: no output; `avs_readdatavalid=0`.
- After the last write beat is accepted, a read may be accepted in the next cycle.

## Configuration
- Macro `AVALON_SLAVE_BRIDGE_READ_FIFO_EN`.
- Defined: read FIFO, registered read outputs and credit admission are built as described above.
- Undefined:
  - No FIFO and no `outstanding` counter.
  - `rready=1`, `avs_readdata=rdata`, `avs_readdatavalid=rvalid` (combinational, 0 cycles).
  - `credit_ok` is treated as 1.
  - Write behaviour is identical.

## Test plan
- Single write: addr 0x100, burstcount 1, awready=wready=1 → `awvalid` and `wvalid` for one cycle, `wlast=1`, `awlen=0`, FSM stays IDLE.
- 4-beat write, wready low on beat 3 for 2 cycles:
  - `awvalid` only on beat 1 and `awlen=3`.
  - `avs_waitrequest` high for 2 cycles.
  - `wlast` only on beat 4, then return to IDLE.
- Read burst of 8 with FIFO, rvalid on 8 consecutive cycles → 8 `avs_readdatavalid` beats, each 1 cycle later in order; `outstanding` returns to 0.
- Credit limit with C_RFIFO_DEPTH=16: read of 12 accepted, then read of 8 gets `avs_waitrequest=1` and `arvalid=0` until ≥4 beats pop, then it is accepted.
- ARESET asserted during beat 2 of a 4-beat write → immediately IDLE with `wvalid=0`. The next write of burstcount 2 gives `awvalid` on beat 1 and `wlast` on beat 2.
- burstcount=0 write → treated as 1: `awlen=0`, `wlast=1`.
